// File: rtl/count_seq_checker.sv
// count_seq_checker: downstream monitor for a mod-MOD cycling counter.
// Locks onto the sequence after LOCK_CNT correct successors, then flags
// skips, stalls and out-of-range values, and counts legal wrap-arounds.
// Optional feature macro: COUNT_SEQ_ERRCNT_EN (adds the saturating err_cnt output).
module count_seq_checker #(
    parameter int unsigned MOD      = 7,
    parameter int unsigned CW       = 3,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     count_in,
    input  logic              count_vld,
    input  logic              err_clr,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic              wrap_pulse,
`ifdef COUNT_SEQ_ERRCNT_EN
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [7:0]        err_cnt
`else
    output logic [WRAP_W-1:0] wrap_cnt
`endif
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       prev_q, prev_d;
    logic [GW-1:0]       good_q, good_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic                err_sticky_q, err_sticky_d;
    logic                wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
`ifdef COUNT_SEQ_ERRCNT_EN
    logic [7:0]          err_cnt_q, err_cnt_d;
`endif

    logic                oor_c;
    logic                prev_top_c;
    logic [CW-1:0]       succ_c;
    logic                is_succ_c;
    logic                err_hit_c;
    logic                wrap_hit_c;

    // Successor of the previous sample and range check of the current one.
    always_comb begin
        oor_c      = ({1'b0, count_in} >= (CW+1)'(MOD));
        prev_top_c = (prev_q == CW'(MOD - 1));
        succ_c     = prev_top_c ? '0 : prev_q + CW'(1);
        is_succ_c  = (count_in == succ_c);
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            good_q       <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
`ifdef COUNT_SEQ_ERRCNT_EN
            err_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
`ifdef COUNT_SEQ_ERRCNT_EN
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    // Next-state and output decode; only valid samples advance the tracker.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_d       = good_q;
        err_hit_c    = 1'b0;
        wrap_hit_c   = 1'b0;

        if (count_vld) begin
            if (!oor_c) begin
                prev_d = count_in;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (!oor_c) begin
                        good_d  = '0;
                        state_d = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (oor_c) begin
                        good_d  = '0;
                        state_d = ST_IDLE;
                    end else if (is_succ_c) begin
                        good_d = good_q + GW'(1);
                        if (good_q == GW'(LOCK_CNT - 1)) begin
                            state_d = ST_LOCK;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCK: begin
                    if (oor_c) begin
                        err_hit_c = 1'b1;
                        good_d    = '0;
                        state_d   = ST_IDLE;
                    end else if (is_succ_c) begin
                        wrap_hit_c = prev_top_c;
                    end else begin
                        err_hit_c = 1'b1;
                        good_d    = '0;
                        state_d   = ST_SYNC;
                    end
                end
                default: begin
                    good_d  = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        locked_d     = (state_d == ST_LOCK);
        err_pulse_d  = err_hit_c;
        wrap_pulse_d = wrap_hit_c;

        // A new error beats a coincident clear.
        if (err_hit_c) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end

        // Saturating wrap counter, cleared only by reset.
        if (wrap_hit_c && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
        end else begin
            wrap_cnt_d = wrap_cnt_q;
        end

`ifdef COUNT_SEQ_ERRCNT_EN
        // Saturating error counter; a clear with a new error restarts at one.
        if (err_hit_c) begin
            if (err_clr) begin
                err_cnt_d = 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else if (err_clr) begin
            err_cnt_d = '0;
        end else begin
            err_cnt_d = err_cnt_q;
        end
`endif
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_cnt   = wrap_cnt_q;
`ifdef COUNT_SEQ_ERRCNT_EN
    assign err_cnt    = err_cnt_q;
`endif

endmodule
